range_sweep_gen: RTL and testbench

//   Synthesizable parametrised sweep generator: drives a WIDTH-bit value from start to stop (inclusive) by step.

---
 rtl/range_sweep_gen.sv | 180 ++++++++++++++++++
 tb/tb_range_sweep_gen.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/range_sweep_gen.sv
// Sweep generator: walks a WIDTH-bit value from start to stop by step, with
// optional dwell between values, in single, loop or ping-pong mode.
module range_sweep_gen #(
   parameter int WIDTH   = 8,
   parameter int DWELL_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   cfg_start,
   input  logic [WIDTH-1:0]   cfg_stop,
   input  logic [WIDTH-1:0]   cfg_step,
   input  logic [DWELL_W-1:0] cfg_dwell,
   input  logic [1:0]         cfg_mode,
   input  logic               start,
   input  logic               abort,
   output logic [WIDTH-1:0]   out_val,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_last,
   output logic               busy,
   output logic               done,
   output logic [1:0]         dbg_state
);

   // Handshake: a value transfers on any rising edge where out_valid && out_ready;
   // out_val/out_last are held while out_valid && !out_ready.

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_EMIT  = 2'd1,
      S_DWELL = 2'd2
   } state_t;

   localparam logic [1:0]         MODE_LOOP = 2'b01;
   localparam logic [1:0]         MODE_PP   = 2'b10;
   localparam logic [WIDTH-1:0]   ONE_W     = WIDTH'(1);
   localparam logic [DWELL_W-1:0] ONE_D     = DWELL_W'(1);

   state_t             r_state;
   logic [WIDTH-1:0]   r_start, r_stop, r_step, r_val;
   logic [DWELL_W-1:0] r_dwell, r_cnt;
   logic [1:0]         r_mode;
   logic               r_dn, r_last, r_valid, r_busy, r_done;

   logic [WIDTH-1:0]   w_cfg_step;
   logic [WIDTH:0]     w_up, w_dn;
   logic               w_up_ok, w_dn_ok;
   logic [WIDTH-1:0]   w_nxt_val;
   logic               w_nxt_dn, w_nxt_last, w_fin;

   // Endpoint test for a value about to be presented in a given direction.
   function automatic logic f_is_end(input logic [WIDTH-1:0] v, input logic dn,
                                     input logic [WIDTH-1:0] lo, input logic [WIDTH-1:0] hi,
                                     input logic [WIDTH-1:0] stp);
      logic [WIDTH:0] up_s;
      logic [WIDTH:0] dn_s;
      up_s = {1'b0, v} + {1'b0, stp};
      dn_s = {1'b0, v} - {1'b0, stp};
      if (lo > hi)
         return 1'b1;
      if (dn)
         return dn_s[WIDTH] || (dn_s[WIDTH-1:0] < lo);
      return up_s[WIDTH] || (up_s[WIDTH-1:0] > hi);
   endfunction

   assign w_cfg_step = (cfg_step == '0) ? ONE_W : cfg_step;
   assign w_up       = {1'b0, r_val} + {1'b0, r_step};
   assign w_dn       = {1'b0, r_val} - {1'b0, r_step};
   assign w_up_ok    = !w_up[WIDTH] && (w_up[WIDTH-1:0] <= r_stop);
   assign w_dn_ok    = !w_dn[WIDTH] && (w_dn[WIDTH-1:0] >= r_start);

   always_comb begin
      w_nxt_val = r_val;
      w_nxt_dn  = r_dn;
      w_fin     = 1'b0;
      if (!r_last) begin
         w_nxt_val = r_dn ? w_dn[WIDTH-1:0] : w_up[WIDTH-1:0];
      end else begin
         case (r_mode)
            MODE_LOOP: begin
               w_nxt_val = r_start;
               w_nxt_dn  = 1'b0;
            end
            MODE_PP: begin
               // Reverse; when the reversed step leaves the range, repeat the value.
               w_nxt_dn = !r_dn;
               if (r_dn && w_up_ok)
                  w_nxt_val = w_up[WIDTH-1:0];
               else if (!r_dn && w_dn_ok)
                  w_nxt_val = w_dn[WIDTH-1:0];
            end
            default: w_fin = 1'b1;
         endcase
      end
      w_nxt_last = f_is_end(w_nxt_val, w_nxt_dn, r_start, r_stop, r_step);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_start <= '0;
         r_stop  <= '0;
         r_step  <= '0;
         r_dwell <= '0;
         r_mode  <= '0;
         r_val   <= '0;
         r_cnt   <= '0;
         r_dn    <= 1'b0;
         r_last  <= 1'b0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (abort) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start) begin
                     r_start <= cfg_start;
                     r_stop  <= cfg_stop;
                     r_step  <= w_cfg_step;
                     r_dwell <= cfg_dwell;
                     r_mode  <= cfg_mode;
                     r_val   <= cfg_start;
                     r_dn    <= 1'b0;
                     r_last  <= f_is_end(cfg_start, 1'b0, cfg_start, cfg_stop, w_cfg_step);
                     r_valid <= 1'b1;
                     r_busy  <= 1'b1;
                     r_state <= S_EMIT;
                  end
               end
               S_EMIT: begin
                  if (out_ready) begin
                     if (w_fin) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end else begin
                        r_val  <= w_nxt_val;
                        r_dn   <= w_nxt_dn;
                        r_last <= w_nxt_last;
                        if (r_dwell != '0) begin
                           r_state <= S_DWELL;
                           r_valid <= 1'b0;
                           r_cnt   <= r_dwell;
                        end
                     end
                  end
               end
               S_DWELL: begin
                  if (r_cnt == ONE_D) begin
                     r_state <= S_EMIT;
                     r_valid <= 1'b1;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt - ONE_D;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign out_val   = r_val;
   assign out_valid = r_valid;
   assign out_last  = r_last;
   assign busy      = r_busy;
   assign done      = r_done;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_range_sweep_gen.sv
// Bench for range_sweep_gen: table of sweep configurations with expected value
// sequences, plus hand-written abort and reset-mid-dwell sequences.
module tb_range_sweep_gen;

   localparam int W  = 8;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  cfg_start, cfg_stop, cfg_step;
   logic [DW-1:0] cfg_dwell;
   logic [1:0]    cfg_mode;
   logic          start, abort, out_ready;
   logic [W-1:0]  out_val;
   logic          out_valid, out_last, busy, done;
   logic [1:0]    dbg_state;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] exp_q[$];
   logic         last_q[$];

   typedef struct {
      logic [1:0]    mode;
      logic [W-1:0]  st;
      logic [W-1:0]  sp;
      logic [W-1:0]  stp;
      logic [DW-1:0] dw;
      int            n;
      logic [W-1:0]  vals [16];
      logic [15:0]   lmask;
      bit            rnd;
   } vec_t;

   vec_t tv [12];

   range_sweep_gen #(.WIDTH(W), .DWELL_W(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_start (cfg_start),
      .cfg_stop  (cfg_stop),
      .cfg_step  (cfg_step),
      .cfg_dwell (cfg_dwell),
      .cfg_mode  (cfg_mode),
      .start     (start),
      .abort     (abort),
      .out_val   (out_val),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, req);
      end
   endtask

   task automatic set_vec(input int i, input logic [1:0] mode, input int st, input int sp,
                          input int stp, input int dw, input int n, input logic [15:0] lmask,
                          input bit rnd);
      tv[i].mode  = mode;
      tv[i].st    = W'(st);
      tv[i].sp    = W'(sp);
      tv[i].stp   = W'(stp);
      tv[i].dw    = DW'(dw);
      tv[i].n     = n;
      tv[i].lmask = lmask;
      tv[i].rnd   = rnd;
   endtask

   task automatic launch(input logic [1:0] mode, input logic [W-1:0] st, input logic [W-1:0] sp,
                         input logic [W-1:0] stp, input logic [DW-1:0] dw);
      cfg_mode  = mode;
      cfg_start = st;
      cfg_stop  = sp;
      cfg_step  = stp;
      cfg_dwell = dw;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      cfg_mode  = 2'($urandom_range(0, 3));
      cfg_start = W'($urandom_range(0, 255));
      cfg_stop  = W'($urandom_range(0, 255));
      cfg_step  = W'($urandom_range(0, 255));
      cfg_dwell = DW'($urandom_range(0, 9));
   endtask

   task automatic run_vec(input vec_t v, input int id);
      int           cnt;
      int           gap;
      int           cyc;
      bit           stall;
      bit           seen_done;
      logic [W-1:0] held;
      logic [W-1:0] ev;
      logic         el;
      bit           single;
      single = (v.mode == 2'b00) || (v.mode == 2'b11);
      for (int i = 0; i < v.n; i++) begin
         exp_q.push_back(v.vals[i]);
         last_q.push_back(v.lmask[i]);
      end
      launch(v.mode, v.st, v.sp, v.stp, v.dw);
      cnt = 0; gap = 0; cyc = 0; stall = 0; seen_done = 0; held = '0;
      while (cnt < v.n && cyc < 300) begin
         if (done) seen_done = 1;
         if (cyc == 0) chk($sformatf("v%0d_latency", id), 32'(out_valid), 32'd1);
         if (stall) chk($sformatf("v%0d_hold", id), {23'd0, out_valid, out_val}, {23'd0, 1'b1, held});
         out_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_valid) begin
            if (out_ready) begin
               ev = exp_q.pop_front();
               el = last_q.pop_front();
               chk($sformatf("v%0d_val%0d", id, cnt), 32'(out_val), 32'(ev));
               chk($sformatf("v%0d_last%0d", id, cnt), 32'(out_last), 32'(el));
               if (cnt > 0) chk($sformatf("v%0d_gap%0d", id, cnt), gap, 32'(v.dw));
               gap = 0;
               cnt++;
               stall = 0;
            end else begin
               stall = 1;
               held  = out_val;
            end
         end else begin
            gap++;
         end
         cyc++;
         if (cnt < v.n) @(negedge clk);
      end
      if (cnt < v.n) chk($sformatf("v%0d_timeout", id), cnt, v.n);
      exp_q.delete();
      last_q.delete();
      @(negedge clk);
      out_ready = 1'b0;
      if (single) begin
         chk($sformatf("v%0d_done", id), 32'(done), 32'd1);
         chk($sformatf("v%0d_busy_end", id), 32'(busy), 32'd0);
         chk($sformatf("v%0d_valid_end", id), 32'(out_valid), 32'd0);
         @(negedge clk);
         chk($sformatf("v%0d_done_pulse", id), 32'(done), 32'd0);
      end else begin
         chk($sformatf("v%0d_no_done", id), 32'(done), 32'd0);
         chk($sformatf("v%0d_still_busy", id), 32'(busy), 32'd1);
         abort = 1'b1;
         @(negedge clk);
         abort = 1'b0;
         chk($sformatf("v%0d_abort_valid", id), 32'(out_valid), 32'd0);
         chk($sformatf("v%0d_abort_busy", id), 32'(busy), 32'd0);
         chk($sformatf("v%0d_abort_done", id), 32'(done), 32'd0);
      end
      chk($sformatf("v%0d_early_done", id), 32'(seen_done), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      // Expected value sequences; lmask bit i marks out_last on the i-th accept.
      set_vec(0,  2'b00, 3,   9,   2, 0, 4,  16'b1000, 0);
      tv[0].vals  = '{0:3, 1:5, 2:7, 3:9, default:0};
      set_vec(1,  2'b00, 250, 255, 4, 0, 2,  16'b10, 0);
      tv[1].vals  = '{0:250, 1:254, default:0};
      set_vec(2,  2'b01, 0,   2,   1, 3, 5,  16'b00100, 0);
      tv[2].vals  = '{0:0, 1:1, 2:2, 3:0, 4:1, default:0};
      set_vec(3,  2'b10, 1,   4,   1, 0, 8,  16'b0100_1000, 0);
      tv[3].vals  = '{0:1, 1:2, 2:3, 3:4, 4:3, 5:2, 6:1, 7:2, default:0};
      set_vec(4,  2'b00, 0,   15,  1, 0, 16, 16'h8000, 1);
      tv[4].vals  = '{0:0, 1:1, 2:2, 3:3, 4:4, 5:5, 6:6, 7:7, 8:8, 9:9, 10:10,
                      11:11, 12:12, 13:13, 14:14, 15:15};
      set_vec(5,  2'b00, 9,   5,   1, 0, 1,  16'b1, 0);
      tv[5].vals  = '{0:9, default:0};
      set_vec(6,  2'b00, 5,   7,   0, 1, 3,  16'b100, 0);
      tv[6].vals  = '{0:5, 1:6, 2:7, default:0};
      set_vec(7,  2'b10, 4,   4,   1, 0, 3,  16'b111, 0);
      tv[7].vals  = '{0:4, 1:4, 2:4, default:0};
      set_vec(8,  2'b11, 0,   1,   1, 0, 2,  16'b10, 0);
      tv[8].vals  = '{0:0, 1:1, default:0};
      set_vec(9,  2'b01, 7,   3,   2, 2, 3,  16'b111, 0);
      tv[9].vals  = '{0:7, 1:7, 2:7, default:0};
      set_vec(10, 2'b10, 0,   10,  4, 0, 6,  16'b010100, 1);
      tv[10].vals = '{0:0, 1:4, 2:8, 3:4, 4:0, 5:4, default:0};
      set_vec(11, 2'b10, 250, 255, 3, 0, 4,  16'b1110, 0);
      tv[11].vals = '{0:250, 1:253, 2:250, 3:253, default:0};

      rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
      cfg_start = '0; cfg_stop = '0; cfg_step = '0; cfg_dwell = '0; cfg_mode = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_val",   32'(out_val),   32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_last",  32'(out_last),  32'd0);
      chk("rst_busy",  32'(busy),      32'd0);
      chk("rst_done",  32'(done),      32'd0);
      chk("rst_state", 32'(dbg_state), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 12; i++) run_vec(tv[i], i);

      // Abort while the third value is on the output.
      out_ready = 1'b1;
      launch(2'b00, 8'd0, 8'd9, 8'd1, 16'd0);
      @(negedge clk);
      @(negedge clk);
      chk("ab_third_val", 32'(out_val), 32'd2);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("ab_valid", 32'(out_valid), 32'd0);
      chk("ab_busy",  32'(busy),      32'd0);
      chk("ab_done",  32'(done),      32'd0);
      @(negedge clk);
      chk("ab_done2", 32'(done), 32'd0);

      // Abort and start together in IDLE: abort wins.
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("abst_busy",  32'(busy),      32'd0);
      chk("abst_valid", 32'(out_valid), 32'd0);

      // Reset while in the dwell gap.
      launch(2'b00, 8'd0, 8'd9, 8'd1, 16'd5);
      chk("rd_first", 32'(out_val), 32'd0);
      @(negedge clk);
      chk("rd_dwell_valid", 32'(out_valid), 32'd0);
      chk("rd_dwell_state", 32'(dbg_state), 32'd2);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("rd_val",   32'(out_val),   32'd0);
      chk("rd_valid", 32'(out_valid), 32'd0);
      chk("rd_busy",  32'(busy),      32'd0);
      chk("rd_done",  32'(done),      32'd0);
      chk("rd_state", 32'(dbg_state), 32'd0);
      out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      chk("rd_idle_busy",  32'(busy),      32'd0);
      chk("rd_idle_valid", 32'(out_valid), 32'd0);
      run_vec(tv[0], 100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
